pipe_stage_ctrl: RTL and testbench

Pipeline stage controller for the 5-stage CPU: consumes the hazard unit's `flush[4:0]`/`stall[4:0]` vectors plus a data-memory wait, normalises them, and drives the per-stage pipeline-register enables and clears. It keeps one valid bit per stage, runs a halt/drain state machine, and flags instruction retirement. Optional performance counters are compiled in by macro. It sits between the hazard unit and the PC / IF-ID / ID-EX / EX-MEM / MEM-WB registers.

---
 rtl/pipe_stage_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage controller: turns hazard flush/stall requests into per-stage enables, clears, valid bits and a halt/drain FSM.
// Bit 4=IF .. 0=WB. Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       flush,
  input  logic [4:0]       stall,
  input  logic             mem_wait,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic [4:0]       reg_en,
  output logic [4:0]       reg_clr,
  output logic [4:0]       valid,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] valid_q, valid_d;
  logic       halted_q, halted_d;

  logic [4:0] raw_stall;
  logic [4:0] s;
  logic       fetch_en;

  // A stall anywhere propagates upstream: s[k] is the OR of requests at k and below.
  always_comb begin
    raw_stall = stall | {3'b000, mem_wait, 1'b0};
    s         = '0;
    s[0]      = raw_stall[0];
    for (int k = 1; k < 5; k++) begin
      s[k] = s[k-1] | raw_stall[k];
    end
  end

  assign fetch_en = (state_q == ST_RUN);

  always_comb begin
    pc_en      = ~s[4] & fetch_en;
    reg_en     = ~s;
    reg_clr    = '0;
    reg_clr[4] = flush[4] | (~s[4] & ~fetch_en);
    // The first moving stage below a held block receives a bubble.
    for (int k = 0; k < 4; k++) begin
      reg_clr[k] = flush[k] | (~s[k] & s[k+1]);
    end
  end

  assign retire = valid_q[0] & ~s[0];

  always_comb begin
    valid_d = '0;
    if (flush[4])  valid_d[4] = 1'b0;
    else if (s[4]) valid_d[4] = valid_q[4];
    else           valid_d[4] = fetch_en;
    for (int k = 0; k < 4; k++) begin
      if (flush[k])      valid_d[k] = 1'b0;
      else if (s[k])     valid_d[k] = valid_q[k];
      else if (s[k+1])   valid_d[k] = 1'b0;
      else               valid_d[k] = valid_q[k+1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_req) state_d = ST_DRAIN;
      ST_DRAIN:  if ((valid_q == 5'b00000) && !mem_wait) state_d = ST_HALTED;
      ST_HALTED: if (resume) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      valid_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign valid  = valid_q;
  assign halted = halted_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q,  cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
  logic             active;

  assign active = (state_q != ST_HALTED);

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (perf_clr) begin
      cycle_cnt_d  = '0;
      retire_cnt_d = '0;
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
    end else begin
      if (active)         cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
      if (retire)         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (s[4] && active) stall_cnt_d  = stall_cnt_q + CNT_W'(1);
      if (|flush)         flush_cnt_d  = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign cycle_cnt       = '0;
  assign retire_cnt      = '0;
  assign stall_cnt       = '0;
  assign flush_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed scenarios then random hazards, checked against a tag-tracking pipeline model.
module tb_pipe_stage_ctrl;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    flush, stall;
  logic          mem_wait, halt_req, resume, perf_clr;
  logic          pc_en, retire, halted;
  logic [4:0]    reg_en, reg_clr, valid;
  logic [CW-1:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .mem_wait(mem_wait),
    .halt_req(halt_req), .resume(resume), .perf_clr(perf_clr),
    .pc_en(pc_en), .reg_en(reg_en), .reg_clr(reg_clr), .valid(valid),
    .retire(retire), .halted(halted),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Model: each stage holds an instruction id (0 = empty); mode 0=run 1=drain 2=halted.
  int            m_mode;
  int            m_tag[5];
  int            m_next_id;
  logic [CW-1:0] m_cyc, m_ret, m_stl, m_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_next_id = 1;
    for (int k = 0; k < 5; k++) m_tag[k] = 0;
    m_cyc = '0; m_ret = '0; m_stl = '0; m_fl = '0;
  endtask

  function automatic logic [4:0] model_valid();
    logic [4:0] v;
    for (int k = 0; k < 5; k++) v[k] = (m_tag[k] != 0);
    return v;
  endfunction

  task automatic drive(input logic [4:0] fl, input logic [4:0] st, input logic mw,
                       input logic hr, input logic rs, input logic pc);
    flush = fl; stall = st; mem_wait = mw; halt_req = hr; resume = rs; perf_clr = pc;
  endtask

  task automatic check_regs();
    chk("valid", valid, model_valid());
    chk("halted", halted, m_mode == 2);
`ifdef PIPE_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("retire_cnt", retire_cnt, m_ret);
    chk("stall_cnt", stall_cnt, m_stl);
    chk("flush_cnt", flush_cnt, m_fl);
`else
    chk("cycle_cnt_off", cycle_cnt, 0);
    chk("retire_cnt_off", retire_cnt, 0);
    chk("stall_cnt_off", stall_cnt, 0);
    chk("flush_cnt_off", flush_cnt, 0);
`endif
  endtask

  // One clock: drive, check combinational outputs, clock, advance model, check registered outputs.
  task automatic step(input logic [4:0] fl, input logic [4:0] st, input logic mw,
                      input logic hr, input logic rs, input logic pc);
    logic [4:0] r, e_en, e_clr;
    bit         held[5];
    bit         fetch, e_ret, e_pc, empty;
    int         low, nt[5];
    drive(fl, st, mw, hr, rs, pc);
    r   = st;
    r[1] = r[1] | mw;
    low = 5;
    for (int k = 0; k < 5; k++) if (r[k] && low == 5) low = k;
    for (int k = 0; k < 5; k++) held[k] = (k >= low);
    fetch = (m_mode == 0);
    e_pc  = !held[4] && fetch;
    for (int k = 0; k < 5; k++) begin
      e_en[k]  = !held[k];
      if (k == 4) e_clr[k] = fl[k] || (!held[k] && !fetch);
      else        e_clr[k] = fl[k] || (!held[k] && held[k+1]);
    end
    e_ret = (m_tag[0] != 0) && !held[0];
    #1;
    chk("pc_en", pc_en, e_pc);
    chk("reg_en", reg_en, e_en);
    chk("reg_clr", reg_clr, e_clr);
    chk("retire", retire, e_ret);
    @(posedge clk);
    empty = (model_valid() == 5'b00000);
    for (int k = 0; k < 5; k++) begin
      if (fl[k])            nt[k] = 0;
      else if (held[k])     nt[k] = m_tag[k];
      else if (k == 4) begin
        if (fetch) begin nt[k] = m_next_id; m_next_id++; end
        else nt[k] = 0;
      end
      else                  nt[k] = held[k+1] ? 0 : m_tag[k+1];
    end
`ifdef PIPE_PERF_CNT_EN
    if (pc) begin
      m_cyc = '0; m_ret = '0; m_stl = '0; m_fl = '0;
    end else begin
      if (m_mode != 2)            m_cyc++;
      if (e_ret)                  m_ret++;
      if (held[4] && m_mode != 2) m_stl++;
      if (fl != 5'b00000)         m_fl++;
    end
`endif
    for (int k = 0; k < 5; k++) m_tag[k] = nt[k];
    if (m_mode == 0 && hr)                 m_mode = 1;
    else if (m_mode == 1 && empty && !mw)  m_mode = 2;
    else if (m_mode == 2 && rs)            m_mode = 0;
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] fill;
    logic [4:0] rf, rs_v;
    rst_n = 1'b0;
    drive(5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pc_en", pc_en, 1'b1);
    chk("rst_reg_en", reg_en, 5'b11111);
    check_regs();

    // Fill from empty.
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      fill = 5'b11111;
      fill = fill << (5 - ((i > 5) ? 5 : i));
      chk("fill_valid", valid, fill);
    end

    // Two-stage stall with a full pipe.
    drive(5'b00000, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall_pc_en", pc_en, 1'b0);
    chk("stall_reg_en", reg_en, 5'b00111);
    chk("stall_reg_clr", reg_clr, 5'b00100);
    step(5'b00000, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_valid", valid, 5'b11011);
    idle(5);

    // Flush beats stall on IF.
    drive(5'b10000, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fs_clr4", reg_clr[4], 1'b1);
    chk("fs_pc_en", pc_en, 1'b0);
    step(5'b10000, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fs_valid4", valid[4], 1'b0);
    idle(5);

    // Data memory wait for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      drive(5'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("mw_reg_en", reg_en, 5'b00001);
      chk("mw_clr0", reg_clr[0], 1'b1);
      chk("mw_retire", retire, (i == 0));
      step(5'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(5);

    // Halt, drain, resume.
    step(5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      drive(5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("drain_pc_en", pc_en, 1'b0);
      idle(1);
      chk("drain_halted", halted, (i == 6));
    end
    idle(3);
    step(5'b0, 5'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("resume_pc_en", pc_en, 1'b1);
    step(5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random hazards with a mid-run asynchronous reset.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 5; k++) begin
        rf[k]   = ($urandom_range(0, 11) == 0);
        rs_v[k] = ($urandom_range(0, 7) == 0);
      end
      step(rf, rs_v, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      if (n == 150) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        drive(5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
